pl_fetch_pc_unit: RTL
=====================

// Module: pl_fetch_pc_unit
// PURPOSE
//  Parametrised fetch-stage program counter for the MIPS pipeline. Holds the PC,
//  selects the next PC by fixed priority (reset, exception, redirect, stall,
//  return prediction, sequential), and owns a small circular return-address
//  stack (RAS) that predicts JR $ra targets. Sits in IF and feeds the I-memory
//  address and the IF/ID register.
// PARAMETERS
//  WIDTH       32            PC / address width in bits
//  RESET_PC    32'h0000_0000 PC value loaded on reset
//  EXC_VECTOR  32'h8000_0180 PC value loaded on exception
//  STEP        4             sequential increment (bytes per instruction)
//  RAS_DEPTH   4             RAS entries; power of two, >= 2
// PORTS
//  clk           in   1        clock, rising edge
//  reset         in   1        synchronous, active-high
//  enable        in   1        1 = advance, 0 = stall (hold PC, RAS untouched)
//  exc_valid     in   1        exception taken; load EXC_VECTOR, flush RAS
//  redirect_valid in  1        branch/jump resolved or mispredict; load redirect_pc
//  redirect_pc   in   WIDTH    redirect target
//  ras_push      in   1        call (JAL/JALR) in decode; push ras_link
//  ras_link      in   WIDTH    return address to push
//  pred_ret      in   1        fetched instruction pre-decoded as JR $ra
//  pc            out  WIDTH    current fetch PC (registered)
//  pc_plus_step  out  WIDTH    pc + STEP, combinational, modulo 2^WIDTH
//  pred_taken    out  1        pred_ret && ras_count != 0, combinational
//  ras_top       out  WIDTH    top RAS entry; 0 when ras_count == 0
//  ras_count     out  $clog2(RAS_DEPTH+1)  valid RAS entries
// BEHAVIOUR
//  - Reset (sync, active-high): pc=RESET_PC, ras_count=0, RAS ptr=0, entries 0.
//  - Next-PC priority, evaluated every rising edge:
//    1 reset -> RESET_PC
//    2 exc_valid -> EXC_VECTOR (ignores enable); RAS count/ptr cleared
//    3 redirect_valid -> redirect_pc (ignores enable); RAS unchanged
//    4 !enable -> hold pc
//    5 pred_taken -> ras_top; pop (count-1, ptr-1)
//    6 else -> pc + STEP (wraps modulo 2^WIDTH)
//  - Latency: one cycle from any select input to pc; no bubbles inserted here.
//  - Push: ras_push && enable && !exc_valid -> ptr+1 (mod RAS_DEPTH), write
//    ras_link, count = min(count+1, RAS_DEPTH). Push on redirect cycle allowed.
//  - Full push: oldest entry overwritten (circular), count saturates at DEPTH.
//  - Empty pop: pred_taken=0, fall through to pc+STEP, count stays 0.
//  - Push and pop same cycle: top entry replaced by ras_link, count unchanged;
//    next pc = old ras_top.
//  - Pop only occurs when rule 5 selected (not on stall/redirect/exception).
//  - Exception with ras_push same cycle: exception wins, RAS ends empty.
//  - Mid-operation reset overrides everything on that edge.
// TESTING
//  1 reset 2 cycles, enable=1, no events -> pc 0,4,8,12; ras_count=0.
//  2 enable=0 for 3 cycles at pc=0x10 -> pc holds 0x10; redirect_pc=0x40 with
//    enable=0 -> pc=0x40 next cycle.
//  3 exc_valid and redirect_valid (0x40) together at pc=0x20 -> pc=0x80000180,
//    ras_count=0.
//  4 push 0x100,0x200; pred_ret -> pc=0x200, ras_count=1; pred_ret -> pc=0x100,
//    count=0; pred_ret again -> pc=0x104-style sequential (pc+4), count=0.
//  5 RAS_DEPTH=4: push 0xA0..0xE0 (5 pushes) -> count=4, ras_top=0xE0; four pops
//    return 0xE0,0xD0,0xC0,0xB0 (0xA0 lost).
//  6 pc=0xFFFF_FFFC, no events -> pc=0x0000_0000; push+pred_ret same cycle with
//    top=0x300, link=0x400 -> pc=0x300, ras_top=0x400, count unchanged.

Source files
------------

// File: rtl/pl_fetch_pc_unit.sv
// pl_fetch_pc_unit: fetch-stage PC with fixed-priority next-PC select and a circular return-address stack
module pl_fetch_pc_unit #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [WIDTH-1:0] EXC_VECTOR = 32'h8000_0180,
  parameter int STEP = 4,
  parameter int RAS_DEPTH = 4,
  localparam int CW = $clog2(RAS_DEPTH + 1),
  localparam int PW = $clog2(RAS_DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             exc_valid,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic             ras_push,
  input  logic [WIDTH-1:0] ras_link,
  input  logic             pred_ret,
  output logic [WIDTH-1:0] pc,
  output logic [WIDTH-1:0] pc_plus_step,
  output logic             pred_taken,
  output logic [WIDTH-1:0] ras_top,
  output logic [CW-1:0]    ras_count
);
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [PW-1:0]    ptr, ptr_inc, ptr_dec;
  logic [WIDTH-1:0] next_pc;
  logic             push, pop;
  assign pc_plus_step = pc + WIDTH'(STEP);
  assign pred_taken   = pred_ret && (ras_count != '0);
  assign ras_top      = (ras_count != '0) ? ras_q[ptr] : '0;
  assign ptr_inc      = ptr + 1'b1;
  assign ptr_dec      = ptr - 1'b1;
  // a pop only happens when the prediction actually steers the PC
  assign pop  = enable && !exc_valid && !redirect_valid && pred_taken;
  assign push = ras_push && enable && !exc_valid;
  always_comb
    next_pc = exc_valid      ? EXC_VECTOR :
              redirect_valid ? redirect_pc :
              !enable        ? pc :
              pred_taken     ? ras_top : pc_plus_step;
  always_ff @(posedge clk) begin
    if (reset) begin
      pc        <= RESET_PC;
      ptr       <= '0;
      ras_count <= '0;
      ras_q     <= '{default: '0};
    end else begin
      pc <= next_pc;
      if (exc_valid) begin
        ptr       <= '0;
        ras_count <= '0;
      end else if (push && pop) begin
        ras_q[ptr] <= ras_link;
      end else if (push) begin
        ras_q[ptr_inc] <= ras_link;
        ptr            <= ptr_inc;
        ras_count      <= (ras_count == CW'(RAS_DEPTH)) ? ras_count : ras_count + 1'b1;
      end else if (pop) begin
        ptr       <= ptr_dec;
        ras_count <= ras_count - 1'b1;
      end
    end
  end
endmodule
